// File: rtl/fifo_flag_status_reg.sv
// Registered FIFO status unit: pointer-derived occupancy, hysteretic almost flags,
// sticky error flags, peak watermark and runtime-programmable thresholds.
module fifo_flag_status_reg #(
    parameter int ADDR_W      = 3,
    parameter int A_FULL_DEF  = 6,
    parameter int A_EMPTY_DEF = 2,
    parameter int HALF_VAL    = 4,
    parameter int HYST        = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W:0]   wr_ptr,
    input  logic [ADDR_W:0]   rd_ptr,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              cfg_load,
    input  logic [ADDR_W:0]   cfg_a_full,
    input  logic [ADDR_W:0]   cfg_a_empty,
    input  logic              clr_sticky,
    output logic [ADDR_W:0]   occupancy,
    output logic              f_full,
    output logic              f_empty,
    output logic              f_almost_full,
    output logic              f_almost_empty,
    output logic              f_half,
    output logic              f_healthy,
    output logic              f_overflow,
    output logic              f_underflow,
    output logic              f_ptr_err,
    output logic [ADDR_W:0]   peak_occ,
    output logic              cfg_err
);

    localparam int PW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
    localparam logic [PW-1:0] HALF_V  = PW'(HALF_VAL);
    localparam logic [PW-1:0] HYST_V  = PW'(HYST);
    localparam logic [PW:0]   HYST_X  = (PW+1)'(HYST);

    logic [PW-1:0] occ_q, occ_d;
    logic [PW-1:0] peak_q, peak_d;
    logic [PW-1:0] thr_af_q, thr_af_d;
    logic [PW-1:0] thr_ae_q, thr_ae_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          half_q, half_d;
    logic          healthy_q, healthy_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          perr_q, perr_d;
    logic          cfg_err_q, cfg_err_d;

    logic [PW-1:0] diff;
    logic [PW-1:0] af_lo;
    logic [PW:0]   ae_sum;
    logic [PW-1:0] ae_hi;
    logic [PW-1:0] peak_base;
    logic          ptr_bad;
    logic          cfg_ok;

    always_comb begin
        // NOTE: every variable gets a value on every path (holds assigned up front) so no latch is inferred.
        diff    = wr_ptr - rd_ptr;
        ptr_bad = diff > DEPTH_V;
        occ_d   = ptr_bad ? occ_q : diff;

        full_d  = (occ_d == DEPTH_V);
        empty_d = (occ_d == '0);
        half_d  = (occ_d >= HALF_V);

        // Hysteresis band edges, clamped to the legal occupancy range.
        af_lo  = (thr_af_q > HYST_V) ? (thr_af_q - HYST_V) : '0;
        ae_sum = {1'b0, thr_ae_q} + HYST_X;
        ae_hi  = (ae_sum > {1'b0, DEPTH_V}) ? DEPTH_V : ae_sum[PW-1:0];

        af_d = af_q;
        if (occ_d >= thr_af_q)   af_d = 1'b1;
        else if (occ_d < af_lo)  af_d = 1'b0;

        ae_d = ae_q;
        if (occ_d <= thr_ae_q)   ae_d = 1'b1;
        else if (occ_d > ae_hi)  ae_d = 1'b0;

        healthy_d = ~(full_d | empty_d | af_d | ae_d | half_d);

        // A fresh set condition beats a simultaneous clear.
        ovf_d  = (wr_req & full_q & ~rd_req) | (ovf_q & ~clr_sticky);
        unf_d  = (rd_req & empty_q) | (unf_q & ~clr_sticky);
        perr_d = ptr_bad | (perr_q & ~clr_sticky);

        peak_base = clr_sticky ? occ_q : peak_q;
        peak_d    = (occ_d > peak_base) ? occ_d : peak_base;

        cfg_ok = (cfg_a_empty != '0) && (cfg_a_empty < cfg_a_full) && (cfg_a_full <= DEPTH_V);
        thr_af_d = thr_af_q;
        thr_ae_d = thr_ae_q;
        if (cfg_load && cfg_ok) begin
            thr_af_d = cfg_a_full;
            thr_ae_d = cfg_a_empty;
        end
        cfg_err_d = cfg_load & ~cfg_ok;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q     <= '0;
            peak_q    <= '0;
            thr_af_q  <= PW'(A_FULL_DEF);
            thr_ae_q  <= PW'(A_EMPTY_DEF);
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= 1'b0;
            ae_q      <= 1'b1;
            half_q    <= 1'b0;
            healthy_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            perr_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            occ_q     <= occ_d;
            peak_q    <= peak_d;
            thr_af_q  <= thr_af_d;
            thr_ae_q  <= thr_ae_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            half_q    <= half_d;
            healthy_q <= healthy_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            perr_q    <= perr_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign occupancy      = occ_q;
    assign f_full         = full_q;
    assign f_empty        = empty_q;
    assign f_almost_full  = af_q;
    assign f_almost_empty = ae_q;
    assign f_half         = half_q;
    assign f_healthy      = healthy_q;
    assign f_overflow     = ovf_q;
    assign f_underflow    = unf_q;
    assign f_ptr_err      = perr_q;
    assign peak_occ       = peak_q;
    assign cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_fifo_flag_status_reg.sv
// Bench for fifo_flag_status_reg: directed vector table, reset corner cases, and
// randomized traffic compared against an integer reference model.
module tb_fifo_flag_status_reg;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MOD    = 2 * DEPTH;
    localparam int HYST   = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] wr_ptr, rd_ptr;
    logic       wr_req, rd_req, cfg_load, clr_sticky;
    logic [3:0] cfg_a_full, cfg_a_empty;
    logic [3:0] occupancy, peak_occ;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_half, f_healthy;
    logic       f_overflow, f_underflow, f_ptr_err, cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_flag_status_reg #(
        .ADDR_W(3), .A_FULL_DEF(6), .A_EMPTY_DEF(2), .HALF_VAL(4), .HYST(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .wr_req(wr_req), .rd_req(rd_req),
        .cfg_load(cfg_load), .cfg_a_full(cfg_a_full), .cfg_a_empty(cfg_a_empty),
        .clr_sticky(clr_sticky),
        .occupancy(occupancy), .f_full(f_full), .f_empty(f_empty),
        .f_almost_full(f_almost_full), .f_almost_empty(f_almost_empty),
        .f_half(f_half), .f_healthy(f_healthy), .f_overflow(f_overflow),
        .f_underflow(f_underflow), .f_ptr_err(f_ptr_err),
        .peak_occ(peak_occ), .cfg_err(cfg_err)
    );

    // Flag bundle order: full empty af ae half healthy ovf unf perr
    typedef struct {
        logic [3:0] wr, rd;
        logic [3:0] ctl;   // {wr_req, rd_req, clr_sticky, cfg_load}
        logic [3:0] caf, cae;
        logic [3:0] occ;
        logic [8:0] flags;
        logic [3:0] peak;
        logic       cerr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8:0] dut_flags();
        return {f_full, f_empty, f_almost_full, f_almost_empty, f_half, f_healthy,
                f_overflow, f_underflow, f_ptr_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] wr, input logic [3:0] rd, input logic [3:0] ctl,
                       input logic [3:0] caf, input logic [3:0] cae, input logic [3:0] occ,
                       input logic [8:0] fl, input logic [3:0] pk, input logic ce);
        vec_t v;
        v.wr = wr; v.rd = rd; v.ctl = ctl; v.caf = caf; v.cae = cae;
        v.occ = occ; v.flags = fl; v.peak = pk; v.cerr = ce;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] wr, input logic [3:0] rd, input logic [3:0] ctl,
                         input logic [3:0] caf, input logic [3:0] cae);
        wr_ptr = wr; rd_ptr = rd;
        {wr_req, rd_req, clr_sticky, cfg_load} = ctl;
        cfg_a_full = caf; cfg_a_empty = cae;
    endtask

    // Reference model: occupancy, hysteretic flags, sticky flags and thresholds as integers.
    int m_occ, m_peak, m_taf, m_tae;
    bit m_af, m_ae, m_ovf, m_unf, m_perr, m_cerr;

    task automatic model_reset();
        m_occ = 0; m_peak = 0; m_taf = 6; m_tae = 2;
        m_af = 0; m_ae = 1; m_ovf = 0; m_unf = 0; m_perr = 0; m_cerr = 0;
    endtask

    task automatic model_step();
        int  raw, nocc, lo, hi, base, caf, cae;
        bit  was_full, was_empty;
        raw       = ((int'(wr_ptr) - int'(rd_ptr)) % MOD + MOD) % MOD;
        nocc      = (raw > DEPTH) ? m_occ : raw;
        was_full  = (m_occ == DEPTH);
        was_empty = (m_occ == 0);
        lo = (m_taf - HYST < 0) ? 0 : m_taf - HYST;
        hi = (m_tae + HYST > DEPTH) ? DEPTH : m_tae + HYST;
        if (nocc >= m_taf) m_af = 1; else if (nocc < lo) m_af = 0;
        if (nocc <= m_tae) m_ae = 1; else if (nocc > hi) m_ae = 0;
        m_ovf  = (wr_req && was_full && !rd_req) || (m_ovf && !clr_sticky);
        m_unf  = (rd_req && was_empty) || (m_unf && !clr_sticky);
        m_perr = (raw > DEPTH) || (m_perr && !clr_sticky);
        base   = clr_sticky ? m_occ : m_peak;
        m_peak = (nocc > base) ? nocc : base;
        caf = int'(cfg_a_full);
        cae = int'(cfg_a_empty);
        m_cerr = 0;
        if (cfg_load) begin
            if (cae > 0 && cae < caf && caf <= DEPTH) begin
                m_taf = caf; m_tae = cae;
            end else begin
                m_cerr = 1;
            end
        end
        m_occ = nocc;
    endtask

    task automatic model_compare();
        bit full, empty, half, healthy;
        full    = (m_occ == DEPTH);
        empty   = (m_occ == 0);
        half    = (m_occ >= 4);
        healthy = !(full || empty || half || m_af || m_ae);
        check("rnd_occ",   32'(occupancy), m_occ);
        check("rnd_flags", 32'(dut_flags()),
              32'({full, empty, m_af, m_ae, half, healthy, m_ovf, m_unf, m_perr}));
        check("rnd_peak",  32'(peak_occ), m_peak);
        check("rnd_cerr",  32'(cfg_err), 32'(m_cerr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int occ_t, rd_i;

        // wr, rd, ctl, caf, cae, occ, flags, peak, cfg_err
        add(4'd1,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd1, 9'b000100000, 4'd1, 1'b0);
        add(4'd2,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd2, 9'b000100000, 4'd2, 1'b0);
        add(4'd3,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd3, 9'b000100000, 4'd3, 1'b0);
        add(4'd4,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd4, 9'b000010000, 4'd4, 1'b0);
        add(4'd5,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd5, 9'b000010000, 4'd5, 1'b0);
        add(4'd6,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd6, 9'b001010000, 4'd6, 1'b0);
        add(4'd7,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd7, 9'b001010000, 4'd7, 1'b0);
        add(4'd8,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd8, 9'b101010000, 4'd8, 1'b0);
        add(4'd8,  4'd0,  4'b1100, 4'd0, 4'd0, 4'd8, 9'b101010000, 4'd8, 1'b0);
        add(4'd8,  4'd0,  4'b1000, 4'd0, 4'd0, 4'd8, 9'b101010100, 4'd8, 1'b0);
        add(4'd8,  4'd1,  4'b1010, 4'd0, 4'd0, 4'd7, 9'b001010100, 4'd8, 1'b0);
        add(4'd8,  4'd2,  4'b0010, 4'd0, 4'd0, 4'd6, 9'b001010000, 4'd7, 1'b0);
        add(4'd8,  4'd3,  4'b0000, 4'd0, 4'd0, 4'd5, 9'b001010000, 4'd7, 1'b0);
        add(4'd8,  4'd4,  4'b0000, 4'd0, 4'd0, 4'd4, 9'b000010000, 4'd7, 1'b0);
        add(4'd2,  4'd14, 4'b0000, 4'd0, 4'd0, 4'd4, 9'b000010000, 4'd7, 1'b0);
        add(4'd6,  4'd14, 4'b0000, 4'd0, 4'd0, 4'd8, 9'b101010000, 4'd8, 1'b0);
        add(4'd6,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd6, 9'b001010000, 4'd8, 1'b0);
        add(4'd6,  4'd0,  4'b0001, 4'd7, 4'd1, 4'd6, 9'b001010000, 4'd8, 1'b0);
        add(4'd6,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd6, 9'b001010000, 4'd8, 1'b0);
        add(4'd5,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd5, 9'b000010000, 4'd8, 1'b0);
        add(4'd5,  4'd0,  4'b0001, 4'd3, 4'd5, 4'd5, 9'b000010000, 4'd8, 1'b1);
        add(4'd6,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd6, 9'b000010000, 4'd8, 1'b0);
        add(4'd7,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd7, 9'b001010000, 4'd8, 1'b0);
        add(4'd1,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd1, 9'b000100000, 4'd8, 1'b0);
        add(4'd2,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd2, 9'b000100000, 4'd8, 1'b0);
        add(4'd3,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd3, 9'b000001000, 4'd8, 1'b0);
        add(4'd10, 4'd0,  4'b0000, 4'd0, 4'd0, 4'd3, 9'b000001001, 4'd8, 1'b0);
        add(4'd3,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd3, 9'b000001001, 4'd8, 1'b0);
        add(4'd3,  4'd0,  4'b0010, 4'd0, 4'd0, 4'd3, 9'b000001000, 4'd3, 1'b0);
        add(4'd0,  4'd0,  4'b0000, 4'd0, 4'd0, 4'd0, 9'b010100000, 4'd3, 1'b0);
        add(4'd0,  4'd0,  4'b1100, 4'd0, 4'd0, 4'd0, 9'b010100010, 4'd3, 1'b0);
        add(4'd0,  4'd0,  4'b0110, 4'd0, 4'd0, 4'd0, 9'b010100010, 4'd0, 1'b0);
        add(4'd0,  4'd0,  4'b0010, 4'd0, 4'd0, 4'd0, 9'b010100000, 4'd0, 1'b0);

        // Reset state
        reset_n = 1'b0;
        drive(4'd0, 4'd0, 4'b0000, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_occ",   32'(occupancy), 32'd0);
        check("rst_flags", 32'(dut_flags()), 32'(9'b010100000));
        check("rst_peak",  32'(peak_occ), 32'd0);
        check("rst_cerr",  32'(cfg_err), 32'd0);
        reset_n = 1'b1;

        // Directed vector table
        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].ctl, vecs[i].caf, vecs[i].cae);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_occ", i),   32'(occupancy), 32'(vecs[i].occ));
            check($sformatf("v%0d_flags", i), 32'(dut_flags()), 32'(vecs[i].flags));
            check($sformatf("v%0d_peak", i),  32'(peak_occ), 32'(vecs[i].peak));
            check($sformatf("v%0d_cerr", i),  32'(cfg_err), 32'(vecs[i].cerr));
        end

        // Mid-operation asynchronous reset discards sticky state and thresholds
        drive(4'd8, 4'd0, 4'b1000, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_ovf", 32'(f_overflow), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_occ",   32'(occupancy), 32'd0);
        check("async_flags", 32'(dut_flags()), 32'(9'b010100000));
        check("async_peak",  32'(peak_occ), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(4'd6, 4'd0, 4'b0000, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        check("post_rst_af_default_thr", 32'(f_almost_full), 32'd1);
        check("post_rst_occ", 32'(occupancy), 32'd6);

        // Randomized traffic against the reference model
        reset_n = 1'b0;
        drive(4'd0, 4'd0, 4'b0000, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        occ_t = 0;
        rd_i  = 0;
        for (int n = 0; n < 2000; n++) begin
            occ_t = occ_t + $urandom_range(0, 2) - 1;
            if (occ_t < 0) occ_t = 0;
            if (occ_t > DEPTH) occ_t = DEPTH;
            if ($urandom_range(0, 3) == 0) rd_i = (rd_i + 1) % MOD;
            wr_ptr = 4'((rd_i + occ_t) % MOD);
            rd_ptr = 4'(rd_i);
            if ($urandom_range(0, 31) == 0) wr_ptr = 4'($urandom_range(0, MOD - 1));
            wr_req      = 1'($urandom_range(0, 1));
            rd_req      = 1'($urandom_range(0, 1));
            clr_sticky  = ($urandom_range(0, 15) == 0);
            cfg_load    = ($urandom_range(0, 15) == 0);
            cfg_a_full  = 4'($urandom_range(0, 15));
            cfg_a_empty = 4'($urandom_range(0, 15));
            @(posedge clk);
            model_step();
            #1;
            model_compare();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_flag_status_reg.md
Name: fifo_flag_status_reg

Overview:
Registered, parametrised FIFO status unit. It replaces purely combinational flag decoding with:
- occupancy computed from the wr/rd pointers (each carrying a wrap bit);
- runtime-programmable almost-full/almost-empty thresholds with hysteresis;
- sticky overflow/underflow/pointer-error flags;
- a peak-occupancy watermark.

It sits beside the FIFO memory and pointer counters in the FIFO top level and drives all status outputs to the host.

Parameters:
ADDR_W, 3, pointer address width; DEPTH = 2**ADDR_W
A_FULL_DEF, 6, reset value of almost-full threshold (entries)
A_EMPTY_DEF, 2, reset value of almost-empty threshold (entries)
HALF_VAL, 4, half-flag threshold (entries)
HYST, 1, hysteresis width (entries) on almost flags; 0 disables

Ports:
clk  in  1  system clock, all state rising-edge
reset_n  in  1  asynchronous active-low reset
wr_ptr  in  ADDR_W+1  write pointer, MSB = wrap bit
rd_ptr  in  ADDR_W+1  read pointer, MSB = wrap bit
wr_req  in  1  write attempt this cycle (before FIFO gating)
rd_req  in  1  read attempt this cycle (before FIFO gating)
cfg_load  in  1  load new thresholds
cfg_a_full  in  ADDR_W+1  new almost-full threshold
cfg_a_empty  in  ADDR_W+1  new almost-empty threshold
clr_sticky  in  1  clear overflow/underflow/ptr_err/peak
occupancy  out  ADDR_W+1  registered entry count, 0..DEPTH
f_full  out  1  occupancy == DEPTH
f_empty  out  1  occupancy == 0
f_almost_full  out  1  hysteretic, occupancy >= thr_af
f_almost_empty  out  1  hysteretic, occupancy <= thr_ae
f_half  out  1  occupancy >= HALF_VAL
f_healthy  out  1  none of full/empty/almost_full/almost_empty/half
f_overflow  out  1  sticky: write attempted while full
f_underflow  out  1  sticky: read attempted while empty
f_ptr_err  out  1  sticky: raw pointer difference > DEPTH
peak_occ  out  ADDR_W+1  highest occupancy since reset/clear
cfg_err  out  1  one-cycle pulse: rejected cfg_load

Behaviour:
- Raw count: diff = (wr_ptr - rd_ptr) mod 2**(ADDR_W+1).
  - If diff > DEPTH: next occupancy holds its previous value and f_ptr_err sets.
  - Otherwise: next occupancy = diff.
- All outputs are registered. Latency is 1 clk from a pointer change to occupancy and flags.
- Flags decode from next occupancy, so the flags and occupancy update in the same cycle.
- Reset (asynchronous, reset_n=0):
  - occupancy=0, peak_occ=0;
  - f_empty=1, f_almost_empty=1, all other flags 0, f_healthy=0, cfg_err=0;
  - thr_af=A_FULL_DEF, thr_ae=A_EMPTY_DEF.
  - Deassertion is taken synchronously by the next edge. A reset mid-operation discards all sticky state.
- f_almost_full hysteresis:
  - sets when occ >= thr_af;
  - clears when occ < thr_af - HYST (saturating at 0);
  - otherwise holds.
- f_almost_empty hysteresis:
  - sets when occ <= thr_ae;
  - clears when occ > thr_ae + HYST (saturating at DEPTH);
  - otherwise holds.
- f_full, f_empty and f_half have no hysteresis.
- f_healthy = ~(f_full|f_empty|f_almost_full|f_almost_empty|f_half), computed on the registered values.
- Sticky flags. Conditions are evaluated on the current registered flags:
  - f_overflow sets on wr_req & f_full & ~rd_req (write together with read while full is legal);
  - f_underflow sets on rd_req & f_empty, even when wr_req is high.
- clr_sticky clears f_overflow, f_underflow and f_ptr_err, and resets peak_occ to the current occupancy. If a set condition occurs in the same cycle as clr_sticky, set wins.
- peak_occ updates to next occupancy whenever next occupancy > peak_occ.
- Config load:
  - cfg_load is legal when 0 < cfg_a_empty < cfg_a_full <= DEPTH.
  - Legal load: thresholds update next cycle; hysteretic flags re-evaluate against the new thresholds from that cycle on.
  - Illegal load: thresholds are unchanged and cfg_err pulses high for 1 cycle.
- Wrap-around: pointer wrap past 2**(ADDR_W+1) is handled by modular subtraction. Full is detected when the wrap bits differ and the address bits are equal.

Test Plan:
1. Reset with wr_ptr=rd_ptr=0 -> occupancy=0, f_empty=1, f_almost_empty=1, f_healthy=0, all sticky flags 0.
2. Defaults (ADDR_W=3, HYST=1): step wr_ptr 0..8 with rd_ptr=0 ->
   - f_almost_empty clears at occ 4;
   - f_half sets at 4;
   - f_almost_full sets at 6;
   - f_full sets at 8 (wr_ptr=4'b1000).
   Then step rd_ptr up -> f_almost_full holds at occ 5 and clears at 4.
3. Pointer wrap: wr_ptr=4'b0010, rd_ptr=4'b1110 -> occupancy=4 and f_half=1. wr_ptr=4'b0110, rd_ptr=4'b1110 -> occupancy=8 and f_full=1.
4. Sticky flags:
   - at full, wr_req=1, rd_req=0 -> f_overflow=1 next cycle;
   - wr_req=rd_req=1 at full -> no set;
   - clr_sticky together with a new overflow condition -> f_overflow stays 1.
5. Config:
   - cfg_load with a_full=7, a_empty=1 at occ 6 -> f_almost_full drops at occ < 6 (i.e. 7-HYST);
   - cfg_load with a_full=3, a_empty=5 -> cfg_err 1-cycle pulse, thresholds unchanged.
6. Errors and watermark:
   - wr_ptr=4'b1010, rd_ptr=4'b0000 (diff 10) -> f_ptr_err=1, occupancy holds;
   - peak_occ tracks a maximum of 8;
   - clr_sticky at occ 3 -> peak_occ=3;
   - reset_n low mid-sequence -> all outputs return to reset values immediately.
